// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - bit-reversed to natural order reorder buffer for a 32-point FFT
// Define REORDER_PINGPONG_EN for two banks (write next frame during readout); default is one bank.
module fft_reorder #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_in_r,
  input  logic signed [DATA_W-1:0] data_in_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] data_out_r,
  output logic signed [DATA_W-1:0] data_out_i,
  output logic [4:0]               index_o,
  output logic                     last_o,
  output logic                     err_o
);

`ifdef REORDER_PINGPONG_EN
  localparam int   AW = 6;
  localparam logic PP = 1'b1;
`else
  localparam int   AW = 5;
  localparam logic PP = 1'b0;
`endif

  typedef enum logic {IDLE, READ} state_t;

  state_t state_q, state_d;
  logic [4:0]        wr_cnt, rd_cnt;
  logic [1:0]        full_q;
  logic              wr_bank, rd_bank;
  logic              accept, rd_en, rd_done;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [2*DATA_W-1:0] mem [2**AW];

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

`ifdef REORDER_PINGPONG_EN
  assign wr_addr = {wr_bank, bitrev5(wr_cnt)};
  assign rd_addr = {rd_bank, rd_cnt};
  assign ready_o = !full_q[wr_bank];
`else
  assign wr_addr = bitrev5(wr_cnt);
  assign rd_addr = rd_cnt;
  // The single bank stays busy through the last_o cycle before taking new samples.
  assign ready_o = !full_q[0] && !last_o;
`endif

  assign accept = valid_i && ready_o;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= {data_in_r, data_in_i};
  end

  // Bank bookkeeping: freeing is written first so a same-edge fill of the other bank is unaffected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q  <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 5'd0;
      err_o   <= 1'b0;
    end else begin
      if (rd_done) begin
        full_q[rd_bank] <= 1'b0;
        rd_bank         <= rd_bank ^ PP;
      end
      if (accept) begin
        wr_cnt <= wr_cnt + 5'd1;
        if (wr_cnt == 5'd31) begin
          full_q[wr_bank] <= 1'b1;
          wr_bank         <= wr_bank ^ PP;
        end
      end
      if (valid_i && !ready_o) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (full_q[rd_bank]) state_d = READ;
      READ: if (rd_cnt == 5'd31) state_d = (PP && full_q[~rd_bank]) ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (state_q == READ);
    rd_done = rd_en && (rd_cnt == 5'd31);
  end

  always_ff @(posedge clk) begin
    if (!rst || !rd_en) rd_cnt <= 5'd0;
    else                rd_cnt <= rd_cnt + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst || !rd_en) begin
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      index_o    <= 5'd0;
      last_o     <= 1'b0;
    end else begin
      valid_o                  <= 1'b1;
      {data_out_r, data_out_i} <= mem[rd_addr];
      index_o                  <= rd_cnt;
      last_o                   <= (rd_cnt == 5'd31);
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - scoreboard bench for fft_reorder
module tb_fft_reorder;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_in_r = '0;
  logic [DW-1:0] data_in_i = '0;
  logic          ready_o, valid_o, last_o, err_o;
  logic [DW-1:0] data_out_r, data_out_i;
  logic [4:0]    index_o;

  fft_reorder #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .data_in_r(data_in_r), .data_in_i(data_in_i),
    .ready_o(ready_o), .valid_o(valid_o),
    .data_out_r(data_out_r), .data_out_i(data_out_i),
    .index_o(index_o), .last_o(last_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic [4:0]    idx;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            lat_q[$];
  logic [DW-1:0] fb_r[32];
  logic [DW-1:0] fb_i[32];
  int            fcnt = 0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            run = 0;
  int            max_run = 0;
  int            n_last = 0;
  exp_t          e_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [4:0] rev5(input logic [4:0] a);
    logic [4:0] y;
    for (int b = 0; b < 5; b++) y[b] = a[4-b];
    return y;
  endfunction

  // Called just before the accepting edge; the first output is due 2 edges after it.
  task automatic push_sample(input logic [DW-1:0] r, input logic [DW-1:0] i);
    exp_t e;
    fb_r[fcnt] = r;
    fb_i[fcnt] = i;
    fcnt++;
    if (fcnt == 32) begin
      for (int n = 0; n < 32; n++) begin
        e.r    = fb_r[rev5(5'(n))];
        e.i    = fb_i[rev5(5'(n))];
        e.idx  = 5'(n);
        e.last = (n == 31);
        sb.push_back(e);
      end
      lat_q.push_back(cyc + 3);
      fcnt = 0;
    end
  endtask

  task automatic send(input int base, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid_i   = 1'b1;
      data_in_r = DW'(base + k);
      data_in_i = DW'(-(base + k));
      check_eq("ready", ready_o, 1);
      push_sample(data_in_r, data_in_i);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        valid_i = 1'b0;
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || valid_o) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_timeout", (t < 500), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    fcnt = 0;
    lat_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          check_eq("unexp_valid", valid_o, 0);
        end else begin
          e_m = sb.pop_front();
          check_eq("data_r", data_out_r, e_m.r);
          check_eq("data_i", data_out_i, e_m.i);
          check_eq("index", index_o, e_m.idx);
          check_eq("last", last_o, e_m.last);
          if (e_m.idx == 5'd0 && lat_q.size() != 0) check_eq("latency", cyc, lat_q.pop_front());
        end
        run++;
        if (run > max_run) max_run = run;
        if (last_o) n_last++;
      end else begin
        run = 0;
        check_eq("idle_zero", {data_out_r, data_out_i, index_o, last_o}, 0);
      end
    end
  end

  initial begin
    int last0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_data", {data_out_r, data_out_i, index_o, last_o}, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", ready_o, 1);

    send(0, 32, 0);
    wait_drain();

    send(100, 32, 1);
    wait_drain();

    send(500, 10, 0);
    do_reset();
    repeat (40) @(negedge clk);
    send(0, 32, 0);
    wait_drain();

`ifdef REORDER_PINGPONG_EN
    max_run = 0;
    last0   = n_last;
    send(200, 64, 0);
    wait_drain();
    check_eq("pp_run", max_run, 64);
    check_eq("pp_lasts", n_last - last0, 2);
    check_eq("pp_err", err_o, 0);
`else
    last0 = n_last;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      valid_i   = 1'b1;
      data_in_r = DW'(400 + k);
      data_in_i = DW'(-(400 + k));
      check_eq("ovf_ready", ready_o, (k < 32));
      if (k < 32) push_sample(data_in_r, data_in_i);
    end
    @(negedge clk);
    valid_i = 1'b0;
    check_eq("ovf_err", err_o, 1);
    wait_drain();
    check_eq("ovf_lasts", n_last - last0, 1);
    check_eq("err_sticky", err_o, 1);
`endif

    do_reset();
    check_eq("err_cleared", err_o, 0);
    check_eq("ready_after_rst", ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter DATA_W, default 16, width of each real/imaginary sample component.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low.
REQ-004 valid_i  input  1  data_in_r/data_in_i carry a sample from the last butterfly stage this cycle.
REQ-005 data_in_r  input  DATA_W  signed real part, arriving in bit-reversed index order.
REQ-006 data_in_i  input  DATA_W  signed imaginary part, arriving in bit-reversed index order.
REQ-007 ready_o  output  1  block accepts a sample this cycle when high.
REQ-008 valid_o  output  1  data_out_r/data_out_i/index_o are valid this cycle.
REQ-009 data_out_r  output  DATA_W  signed real part, natural-order output.
REQ-010 data_out_i  output  DATA_W  signed imaginary part, natural-order output.
REQ-011 index_o  output  5  natural frequency index (0..31) of the current output sample.
REQ-012 last_o  output  1  high with valid_o when index_o==31.
REQ-013 err_o  output  1  sticky flag: a sample was presented while ready_o was low.

Function
REQ-014 Frame size fixed at 32 complex samples; 5-bit write counter wr_cnt, 5-bit read counter rd_cnt.
REQ-015 Accept = valid_i && ready_o; on accept, store sample at address bitrev5(wr_cnt) of the current write bank, then wr_cnt increments.
REQ-016 Accept with wr_cnt==31: wr_cnt wraps to 0, write bank marked full on the same edge.
REQ-017 Gaps in valid_i allowed; wr_cnt holds while valid_i low; no timeout.
REQ-018 Read FSM states: IDLE, READ.
REQ-019 IDLE -> READ when a full bank exists; rd_cnt=0 on entry.
REQ-020 In READ, one sample per cycle, no stalls: rd_cnt increments each cycle, output registered from mem[rd_cnt].
REQ-021 Latency: valid_o for index 0 asserts exactly 2 rising edges after the edge accepting the 32nd sample of a frame.
REQ-022 Outputs for one frame: 32 consecutive valid_o cycles, index_o 0..31 ascending, last_o on index 31.
REQ-023 After last output: bank marked empty; READ -> READ (rd_cnt=0) if the other bank is full, else -> IDLE.
REQ-024 When valid_o low: data_out_r, data_out_i, index_o, last_o all 0.
REQ-025 valid_i while ready_o low: sample discarded, wr_cnt unchanged, err_o set and held until reset.
REQ-026 Simultaneous write-bank-full and read-complete on the same edge: bank freeing takes effect first, so ready_o is not lowered.
REQ-027 Arithmetic: none; data passes bit-exact.

Reset
REQ-028 rst low at a rising edge: FSM=IDLE, wr_cnt=0, rd_cnt=0, both banks empty, write bank=0, err_o=0, valid_o=0, all data outputs 0, ready_o=1 from the following cycle.
REQ-029 Reset mid-frame or mid-readout discards the partial/pending frame; sample memory contents are not reset.

Configuration
REQ-030 Macro REORDER_PINGPONG_EN defined: two 32-entry banks; writing of frame n+1 proceeds during readout of frame n; ready_o low only while the write bank is full and unread.
REQ-031 Macro REORDER_PINGPONG_EN undefined: single 32-entry bank; ready_o low from the edge marking the bank full until the edge after the last_o cycle.

Verification
REQ-032 Drive 32 contiguous samples, data_in_r=k, data_in_i=-k for arrival k -> outputs index n carry r=bitrev5(n), i=-bitrev5(n) (n=1 -> 16, n=2 -> 8, n=31 -> 31); first valid_o 2 edges after the 32nd accept.
REQ-033 PINGPONG_EN, two frames back-to-back with no gaps -> ready_o stays 1, 64 contiguous valid_o cycles, two last_o pulses, err_o=0.
REQ-034 PINGPONG_EN undefined, valid_i held high for 40 cycles -> ready_o drops after the 32nd accept, samples 33..40 dropped, err_o=1, only the first frame is output.
REQ-035 Assert rst after 10 accepted samples, then send a fresh 32-sample frame -> no output from the partial frame; fresh frame output matches REQ-032 ordering.
REQ-036 valid_i asserted every other cycle for 32 samples -> output order and values identical to REQ-032; latency measured from the 32nd accept still 2 edges.
